nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_adder_ctrl_binaryadder_4bit.sv | 21 ++
 rtl/nibble_serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared state encoding and nibble width for the serial adder
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_binaryadder_4bit.sv
// rtl/nibble_serial_adder_ctrl_binaryadder_4bit.sv - 4-bit combinational ripple-carry adder
module binaryadder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add/subtract sequenced through one 4-bit adder, LSB nibble first
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIB  = WIDTH / NIBBLE_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b_eff;
  logic                r_carry;
  logic [IDXW-1:0]     r_idx;
  logic [WIDTH-1:0]    r_sum;
  logic                r_c_out;
  logic                r_ovf;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_add_sum;
  logic                w_add_cout;
  logic [WIDTH-1:0]    w_sum_nxt;
  logic                w_last;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand nibble mux and result nibble demux, both steered by r_idx.
  always_comb begin
    w_a_nib   = '0;
    w_b_nib   = '0;
    w_sum_nxt = r_sum;
    for (int k = 0; k < NIB; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b_eff[k*NIBBLE_W +: NIBBLE_W];
        w_sum_nxt[k*NIBBLE_W +: NIBBLE_W] = w_add_sum;
      end
    end
  end

  binaryadder_4bit u_adder (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b_eff <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b_eff <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_sum   <= '0;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_nxt;
          r_carry <= w_add_cout;
          if (w_last) begin
            // Sign bits of both operands, result MSB and carry out of the MSB give overflow.
            r_c_out <= w_add_cout;
            r_ovf   <= r_a[WIDTH-1] ^ r_b_eff[WIDTH-1] ^ w_add_sum[NIBBLE_W-1] ^ w_add_cout;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed self-checking bench for nibble_serial_adder_ctrl
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic isub, input logic icin,
                       input logic [15:0] es, input logic ec, input logic eo);
    int cyc;
    int bcyc;
    @(negedge clk);
    a = ia; b = ib; sub = isub; c_in = icin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
    wait_done(cyc, bcyc);
    chk({tag, "_latency"}, cyc, 5);
    chk({tag, "_busy_cycles"}, bcyc, 5);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 32'(done), 0);
    chk({tag, "_idle_after"}, 32'(busy), 0);
  endtask

  initial begin
    int cyc;
    int bcyc;
    int n_done;
    logic [15:0] ea [3];
    logic [15:0] eb [3];
    logic        esub [3];
    logic        ecin [3];
    logic [15:0] esum [3];
    logic        ecout [3];
    logic        eovf [3];

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_sum", 32'(sum), 0);
    chk("reset_c_out", 32'(c_out), 0);
    chk("reset_ovf", 32'(ovf), 0);
    rst = 1'b0;

    do_op("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("add_cin",     16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0);
    do_op("sub_eq",      16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sub_borrow",  16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    do_op("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Starts presented during RUN and DONE must not disturb the running operation.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ign_done_t5", 32'(done), 1);
    chk("ign_sum", 32'(sum), 32'h2345);
    chk("ign_c_out", 32'(c_out), 0);
    a = 16'h0000; b = 16'h0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    bcyc   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) bcyc++;
    end
    chk("ign_extra_done", 32'(n_done), 0);
    chk("ign_stays_idle", 32'(bcyc), 0);
    chk("ign_sum_held", 32'(sum), 32'h2345);

    // Reset in the third RUN cycle aborts without a done pulse.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_sum", 32'(sum), 0);
    chk("rst_mid_done", 32'(done), 0);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rst_mid_no_done", 32'(n_done), 0);
    do_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Back-to-back with start held high: one acceptance every NIB+2 cycles.
    ea[0] = 16'hAAAA; eb[0] = 16'h5555; esub[0] = 1'b0; ecin[0] = 1'b1;
    esum[0] = 16'h0000; ecout[0] = 1'b1; eovf[0] = 1'b0;
    ea[1] = 16'h0005; eb[1] = 16'h0007; esub[1] = 1'b1; ecin[1] = 1'b0;
    esum[1] = 16'hFFFE; ecout[1] = 1'b0; eovf[1] = 1'b0;
    ea[2] = 16'h4000; eb[2] = 16'h4000; esub[2] = 1'b0; ecin[2] = 1'b0;
    esum[2] = 16'h8000; ecout[2] = 1'b0; eovf[2] = 1'b1;
    @(negedge clk);
    a = ea[0]; b = eb[0]; sub = esub[0]; c_in = ecin[0]; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
      wait_done(cyc, bcyc);
      chk($sformatf("b2b%0d_latency", k), cyc, 5);
      chk($sformatf("b2b%0d_sum", k), 32'(sum), 32'(esum[k]));
      chk($sformatf("b2b%0d_c_out", k), 32'(c_out), 32'(ecout[k]));
      chk($sformatf("b2b%0d_ovf", k), 32'(ovf), 32'(eovf[k]));
      @(negedge clk);
      chk($sformatf("b2b%0d_idle_gap", k), 32'(busy), 0);
      if (k < 2) begin
        a = ea[k+1]; b = eb[k+1]; sub = esub[k+1]; c_in = ecin[k+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_stop", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
